// File: rtl/riscv_pkg.sv
// Shared load/store definitions for the data-memory access stage:
// funct3 encodings, the access FSM states and the latched request record.
package riscv_pkg;

  localparam int MEM_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic                is_load;
    logic [2:0]          funct3;
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] wdata;
    logic [3:0]          we;
    logic [4:0]          rd;
  } mem_req_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/gnt address phase followed by an rvalid read-data phase.
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            gnt;
  logic [XLEN-1:0] addr;
  logic [3:0]      we;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, addr, we, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = '0;
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store access stage: validates a request from execute, runs one bus
// transaction on the data-memory interface and returns a one-cycle writeback.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_addr,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic [3:0]           ex_we,
  input  logic [4:0]           ex_rd,
  mem_access_stage_if.master   dmem,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_err
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  mem_state_t      state_reg, state_next;
  mem_req_t        req_reg, req_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            err_reg, err_next;
  logic [XLEN-1:0] data_reg, data_next;

  logic [XLEN-1:0] rep_byte, rep_half, store_data, load_data;
  logic            ld_bad, st_bad, check_fail, timeout_hit, ld_ok;

  genvar gi;
  generate
    for (gi = 0; gi < XLEN/8; gi++) begin : g_byte_lane
      assign rep_byte[gi*8 +: 8] = ex_wdata[7:0];
    end
    for (gi = 0; gi < XLEN/16; gi++) begin : g_half_lane
      assign rep_half[gi*16 +: 16] = ex_wdata[15:0];
    end
  endgenerate

  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   store_data = rep_byte;
      2'b01:   store_data = rep_half;
      default: store_data = ex_wdata;
    endcase
  end

  // A request flagged as both load and store is treated as a load.
  always_comb begin
    ld_bad = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111) ||
             (((ex_funct3 == F3_H) || (ex_funct3 == F3_HU)) && ex_addr[0]) ||
             ((ex_funct3 == F3_W) && (ex_addr[1:0] != 2'b00));
    st_bad = (ex_we == 4'b0000);
    check_fail = ex_is_load ? ld_bad : st_bad;
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (dmem.rdata),
    .addr_lo (req_reg.addr[1:0]),
    .funct3  (req_reg.funct3),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (ex_valid && (ex_is_load || ex_is_store)) begin
          req_next.is_load = ex_is_load;
          req_next.funct3  = ex_funct3;
          req_next.addr    = ex_addr;
          req_next.wdata   = ex_is_load ? '0 : store_data;
          req_next.we      = ex_is_load ? 4'b0000 : ex_we;
          req_next.rd      = ex_is_load ? ex_rd : 5'd0;
          err_next         = check_fail;
          data_next        = '0;
          cnt_next         = '0;
          state_next       = check_fail ? RESP : REQ;
        end
      end
      REQ: begin
        if (dmem.gnt) begin
          state_next = req_reg.is_load ? WAIT_R : RESP;
          cnt_next   = '0;
        end else if (timeout_hit) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_R: begin
        if (dmem.rvalid) begin
          data_next  = load_data;
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ex_ready   = (state_reg == IDLE);
  assign dmem.req   = (state_reg == REQ);
  assign dmem.addr  = {req_reg.addr[XLEN-1:2], 2'b00};
  assign dmem.we    = (state_reg == REQ) ? req_reg.we : 4'b0000;
  assign dmem.wdata = req_reg.wdata;

  assign ld_ok    = (state_reg == RESP) && req_reg.is_load && !err_reg;
  assign wb_valid = (state_reg == RESP);
  assign wb_we    = ld_ok;
  assign wb_rd    = ld_ok ? req_reg.rd : 5'd0;
  assign wb_data  = ld_ok ? data_reg : '0;
  assign wb_err   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, error paths, bus stalls,
// timeout, mid-transaction reset and back-to-back requests.
module tb_mem_access_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [3:0]  ex_we = 4'b0000;
  logic [4:0]  ex_rd = 5'd0;
  logic        wb_valid, wb_we, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          checks = 0;
  int          errors = 0;

  mem_access_stage_if #(.XLEN(32)) dmem ();

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_we(ex_we), .ex_rd(ex_rd),
    .dmem(dmem.master),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                          input logic [4:0] rd);
    ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_we = we; ex_rd = rd;
  endtask

  task automatic test_reset();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    #3;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b exp 1", ex_ready); end
    checks++; if (dmem.req !== 1'b0 || dmem.we !== 4'b0 || dmem.addr !== 32'h0 || dmem.wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: req=%b we=%h addr=%h wdata=%h exp all 0", dmem.req, dmem.we, dmem.addr, dmem.wdata); end
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_wb: valid=%b we=%b rd=%h data=%h err=%b exp all 0", wb_valid, wb_we, wb_rd, wb_data, wb_err); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] we, input logic [31:0] exp_wdata);
    drive_ex(1'b1, 1'b0, 1'b1, f3, a, wd, we, 5'd7);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    checks++; if (dmem.req !== 1'b1 || ex_ready !== 1'b0) begin errors++; $display("FAIL %s_req: req=%b ready=%b exp 1/0", name, dmem.req, ex_ready); end
    checks++; if (dmem.addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr: got %h exp %h", name, dmem.addr, {a[31:2], 2'b00}); end
    checks++; if (dmem.wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata: got %h exp %h", name, dmem.wdata, exp_wdata); end
    checks++; if (dmem.we !== we) begin errors++; $display("FAIL %s_we: got %b exp %b", name, dmem.we, we); end
    tick();
    dmem.gnt = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_err !== 1'b0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL %s_wb: valid=%b we=%b err=%b rd=%h exp 1/0/0/0", name, wb_valid, wb_we, wb_err, wb_rd); end
    tick();
    checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL %s_end: valid=%b ready=%b exp 0/1", name, wb_valid, ex_ready); end
    $display("txn %s addr=%h done", name, a);
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp_data);
    drive_ex(1'b1, 1'b1, 1'b0, f3, a, 32'hFFFF_FFFF, 4'b1111, rd);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    checks++; if (dmem.req !== 1'b1 || dmem.we !== 4'b0000) begin errors++; $display("FAIL %s_req: req=%b we=%b exp 1/0000", name, dmem.req, dmem.we); end
    tick();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = rdata;
    checks++; if (dmem.req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL %s_wait: req=%b valid=%b exp 0/0", name, dmem.req, wb_valid); end
    tick();
    dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_err !== 1'b0 || wb_rd !== rd) begin
      errors++; $display("FAIL %s_wb: valid=%b we=%b err=%b rd=%h exp 1/1/0/%h", name, wb_valid, wb_we, wb_err, wb_rd, rd); end
    checks++; if (wb_data !== exp_data) begin errors++; $display("FAIL %s_data: got %h exp %h", name, wb_data, exp_data); end
    tick();
    $display("txn %s addr=%h data=%h done", name, a, wb_data);
  endtask

  task automatic test_error(input string name, input logic ld, input logic [2:0] f3,
                            input logic [31:0] a, input logic [3:0] we);
    drive_ex(1'b1, ld, ~ld, f3, a, 32'h1234_5678, we, 5'd9);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL %s_noreq: got %b exp 0", name, dmem.req); end
    checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL %s_wb: valid=%b err=%b we=%b rd=%h exp 1/1/0/0", name, wb_valid, wb_err, wb_we, wb_rd); end
    tick();
    dmem.gnt = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b exp 0", name, wb_valid); end
    $display("txn %s addr=%h done", name, a);
  endtask

  task automatic test_gnt_delay();
    drive_ex(1'b1, 1'b0, 1'b1, F3_W, 32'h4000, 32'hDEAD_BEEF, 4'b1111, 5'd0);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem.req !== 1'b1 || dmem.addr !== 32'h4000 || dmem.wdata !== 32'hDEAD_BEEF || ex_ready !== 1'b0) begin
        errors++; $display("FAIL gnt_delay_hold%0d: req=%b addr=%h wdata=%h ready=%b exp 1/4000/deadbeef/0", i, dmem.req, dmem.addr, dmem.wdata, ex_ready); end
      if (i == 3) dmem.gnt = 1'b1;
      tick();
    end
    dmem.gnt = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b0) begin errors++; $display("FAIL gnt_delay_wb: valid=%b err=%b exp 1/0", wb_valid, wb_err); end
    tick();
    $display("txn gnt_delay done");
  endtask

  task automatic test_timeout();
    drive_ex(1'b1, 1'b1, 1'b0, F3_W, 32'h5000, '0, 4'b0, 5'd3);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    tick();
    dmem.gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (wb_valid !== 1'b0 || dmem.req !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: valid=%b req=%b exp 0/0", i, wb_valid, dmem.req); end
      tick();
    end
    checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL timeout_wb: valid=%b err=%b we=%b exp 1/1/0", wb_valid, wb_err, wb_we); end
    tick();
    $display("txn timeout done");
  endtask

  task automatic test_reset_mid();
    drive_ex(1'b1, 1'b1, 1'b0, F3_W, 32'h6000, '0, 4'b0, 5'd4);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    tick();
    dmem.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1 || dmem.addr !== 32'h0) begin errors++; $display("FAIL rst_mid_async: ready=%b addr=%h exp 1/0", ex_ready, dmem.addr); end
    tick();
    rst_n = 1'b1;
    dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFE_F00D;
    tick();
    dmem.rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || dmem.req !== 1'b0 || wb_data !== 32'h0 || wb_err !== 1'b0) begin
        errors++; $display("FAIL rst_mid_idle%0d: valid=%b ready=%b req=%b data=%h err=%b exp 0/1/0/0/0", i, wb_valid, ex_ready, dmem.req, wb_data, wb_err); end
      tick();
    end
    $display("txn reset_mid done");
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 1'b1, 1'b0, F3_W, 32'h10, '0, 4'b0, 5'd12);
    dmem.gnt = 1'b1;
    tick();
    drive_ex(1'b1, 1'b0, 1'b1, F3_W, 32'h14, 32'h5566_7788, 4'b1111, 5'd0);
    checks++; if (ex_ready !== 1'b0 || dmem.addr !== 32'h10) begin errors++; $display("FAIL b2b_first_req: ready=%b addr=%h exp 0/10", ex_ready, dmem.addr); end
    tick();
    dmem.rvalid = 1'b1; dmem.rdata = 32'h1122_3344;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL b2b_wait_ready: got %b exp 0", ex_ready); end
    tick();
    dmem.rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1122_3344 || wb_rd !== 5'd12 || ex_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first_wb: valid=%b data=%h rd=%h ready=%b exp 1/11223344/0c/0", wb_valid, wb_data, wb_rd, ex_ready); end
    tick();
    checks++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || dmem.req !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: ready=%b valid=%b req=%b exp 1/0/0", ex_ready, wb_valid, dmem.req); end
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, '0, '0, 4'b0, 5'd0);
    checks++; if (dmem.req !== 1'b1 || dmem.addr !== 32'h14 || dmem.we !== 4'b1111 || dmem.wdata !== 32'h5566_7788) begin
      errors++; $display("FAIL b2b_second_req: req=%b addr=%h we=%b wdata=%h exp 1/14/1111/55667788", dmem.req, dmem.addr, dmem.we, dmem.wdata); end
    tick();
    dmem.gnt = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second_wb: valid=%b we=%b err=%b exp 1/0/0", wb_valid, wb_we, wb_err); end
    tick();
    $display("txn back_to_back done");
  endtask

  initial begin
    test_reset();
    test_store("sb", F3_B, 32'h1001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    test_store("sh", F3_H, 32'h6002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store("sw", F3_W, 32'h7004, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
    test_load("lb",   F3_B,  32'h2003, 32'h80FF_1234, 5'd5,  32'hFFFF_FF80);
    test_load("lbu",  F3_BU, 32'h2003, 32'h80FF_1234, 5'd6,  32'h0000_0080);
    test_load("lhu",  F3_HU, 32'h2002, 32'h80FF_1234, 5'd7,  32'h0000_80FF);
    test_load("lh_hi", F3_H, 32'h2002, 32'h80FF_1234, 5'd8,  32'hFFFF_80FF);
    test_load("lh_lo", F3_H, 32'h2000, 32'h80FF_1234, 5'd9,  32'h0000_1234);
    test_load("lw",   F3_W,  32'h2004, 32'h80FF_1234, 5'd31, 32'h80FF_1234);
    test_load("lb_b1", F3_B, 32'h2001, 32'h80FF_1234, 5'd10, 32'h0000_0012);
    test_error("lw_misaligned", 1'b1, F3_W, 32'h3002, 4'b0000);
    test_error("lh_misaligned", 1'b1, F3_H, 32'h3001, 4'b0000);
    test_error("illegal_f3", 1'b1, 3'b011, 32'h3000, 4'b0000);
    test_error("store_we0", 1'b0, F3_W, 32'h3000, 4'b0000);
    test_gnt_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory access stage directly downstream of the S_type byte-enable decoder and the load decoder.
- Accepts one load or store per transaction from execute and drives the data-memory bus with a req/gnt + rvalid handshake.
- Replicates store data across byte lanes and extracts and sign/zero-extends load data.
- Returns a single-cycle writeback pulse, with an error flag for misaligned, illegal or timed-out accesses.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYC, 16, maximum cycles waiting for dmem_gnt or dmem_rvalid; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  request from execute.
- ex_ready  out  1  stage can accept a request.
- ex_is_load  in  1  request is a load.
- ex_is_store  in  1  request is a store.
- ex_funct3  in  3  instr[14:12].
- ex_addr  in  XLEN  effective byte address.
- ex_wdata  in  XLEN  rs2 store data, value in low bits.
- ex_we  in  4  byte enables from S_type, already lane-aligned; 0 means invalid store.
- ex_rd  in  5  load destination register.
- dmem_req  out  1  bus request.
- dmem_gnt  in  1  bus grant.
- dmem_addr  out  XLEN  word-aligned address (addr[1:0]=0).
- dmem_we  out  4  byte write enables; 0 for loads.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_we  out  1  register-file write (loads only).
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  extended load result.
- wb_err  out  1  misaligned, illegal or timeout.

Behaviour:
- Reset: async on rst_n=0. State=IDLE. Outputs: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_err=0. Timeout counter=0.
- ex_ready=1 only in IDLE. Accept when ex_valid && ex_ready. If neither ex_is_load nor ex_is_store is set, the request is ignored.
- Accept-time checks, registered into a request register; any failure goes IDLE->RESP with wb_err=1, wb_we=0 and no bus access:
  - store with ex_we==0;
  - load funct3 in {011,110,111};
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]!=0.
- States and transitions:
  - IDLE: on a valid accept go to REQ, or to RESP if a check fails.
  - REQ: dmem_req=1, with address, we and wdata held stable until dmem_gnt. Grant on a store goes to RESP. Grant on a load goes to WAIT_R.
  - WAIT_R: dmem_req=0. Wait for dmem_rvalid, capture the extracted data, then go to RESP.
  - RESP: wb_valid=1 for exactly one cycle, then IDLE.
- Store data replication:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata unchanged
  - dmem_we = ex_we.
- Load extraction uses a lane select of addr[1:0]:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001): sign-extend the half selected by addr[1].
  - LHU (101): zero-extend that half.
  - LW (010): full word.
- Writeback fields:
  - Loads: wb_we=1, wb_rd=ex_rd.
  - Stores and errors: wb_we=0, wb_rd=0.
- Latency with zero-wait gnt and rvalid one cycle after gnt, accept at edge T:
  - dmem_req high during T+1.
  - Store: wb_valid during T+2.
  - Load: rvalid seen during T+2, wb_valid during T+3.
- Timeout: the counter resets on entry to REQ and to WAIT_R and increments each cycle in those states. On reaching TIMEOUT_CYC: drop dmem_req, go to RESP with wb_err=1, wb_we=0.
- Spurious responses: dmem_rvalid outside WAIT_R is ignored. dmem_gnt outside REQ is ignored.
- Reset mid-transaction: immediate return to IDLE with no wb pulse. A late rvalid after reset is ignored.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - the mem_state_t enum {IDLE, REQ, WAIT_R, RESP};
  - a struct mem_req_t {is_load, funct3, addr, wdata, we, rd}.
- One combinational sub-module, load_align (rdata, addr_lo[1:0], funct3 -> extended data), which the verifier tests exhaustively on its own.

Test Plan:
- SB addr=0x1001, wdata=0x000000A5, we=4'b0010, gnt same cycle as req -> dmem_addr=0x1000, dmem_wdata=0xA5A5A5A5, dmem_we=0010, wb_valid at T+2, wb_we=0, wb_err=0.
- LB addr=0x2003, rdata=0x80FF1234 -> wb_data=0xFFFFFF80, wb_rd=ex_rd; LBU same -> 0x00000080; LHU addr=0x2002 -> 0x000080FF.
- LW addr=0x3002 -> no dmem_req, wb_valid one cycle later with wb_err=1; store with we=0 -> same error response.
- gnt delayed 3 cycles -> dmem_req, addr and wdata stable all 4 cycles, ex_ready=0 throughout; rvalid never arrives with TIMEOUT_CYC=16 -> wb_err=1 after 16 WAIT_R cycles.
- Reset asserted in WAIT_R, rvalid pulses after deassert -> no wb_valid, ex_ready=1, all outputs at reset values.
- Back-to-back LW 0x10 then SW 0x14, ex_valid held high -> second accepted only in the cycle after the first wb_valid; two wb pulses, in order.
